// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scan scheduler for a 6-digit multiplexed seven-segment display.
// Shares one segment bus across six active-low digit enables. A shadow copy of
// the BCD data is reloaded only at frame wrap (or while idle), so a frame never
// mixes old and new digits.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | display off, prescaler held at 0, digit index parked at 0
//   SHOW  | current digit enabled, segments decoded from shadow
//   BLANK | all digits off between two digits (ghost suppression)
//
// All outputs are registered from next-state values, so dig_sel/seg move on
// the same edge as the state register.

module seg_scan_ctrl #(
    parameter int DIV         = 50000,
    parameter int SHOW_TICKS  = 4,
    parameter int BLANK_TICKS = 1,
    parameter int LZB         = 1
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        en,
    input  logic        upd_req,
    input  logic [23:0] bcd_in,
    output logic        upd_ack,
    output logic [5:0]  dig_sel,
    output logic [6:0]  seg,
    output logic [2:0]  dig_idx,
    output logic        frame_done
);

    localparam int CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PH_MAX = (SHOW_TICKS > BLANK_TICKS) ? SHOW_TICKS : BLANK_TICKS;
    localparam int PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [CW-1:0] CNT_TC   = CW'(DIV - 1);
    localparam logic [PW-1:0] SHOW_LD  = PW'(SHOW_TICKS - 1);
    localparam logic [PW-1:0] BLANK_LD = PW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt;
    logic          tick;
    logic [PW-1:0] phase, phase_d;
    logic [2:0]    idx_d;
    logic [23:0]   shadow, shadow_d;
    logic          ack_d, frame_d, advance;
    logic [5:0]    sel_d;
    logic [6:0]    seg_d;
    logic [3:0]    digit;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h7E;
            4'd1:    s = 7'h30;
            4'd2:    s = 7'h6D;
            4'd3:    s = 7'h79;
            4'd4:    s = 7'h33;
            4'd5:    s = 7'h5B;
            4'd6:    s = 7'h5F;
            4'd7:    s = 7'h70;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h7B;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // True when digit idx and every digit above it are zero.
    function automatic logic lead_zero(input logic [23:0] d, input logic [2:0] idx);
        logic nz;
        nz = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k >= int'(idx) && d[4*k +: 4] != 4'h0) nz = 1'b1;
        end
        return !nz;
    endfunction

    assign tick = (state != IDLE) && (cnt == CNT_TC);

    // Scan prescaler: free-runs while scanning, parked at 0 in IDLE.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst)               cnt <= '0;
        else if (state == IDLE) cnt <= '0;
        else if (tick)          cnt <= '0;
        else                    cnt <= cnt + CW'(1);
    end

    // Next-state, digit index and shadow-load decisions.
    always_comb begin
        state_d  = state;
        phase_d  = phase;
        idx_d    = dig_idx;
        shadow_d = shadow;
        ack_d    = 1'b0;
        frame_d  = 1'b0;
        advance  = 1'b0;

        unique case (state)
            IDLE: begin
                idx_d = 3'd0;
                // upd_ack guard stops a requester that is still dropping its
                // request from getting a second ack on the following cycle.
                if (upd_req && !upd_ack) begin
                    shadow_d = bcd_in;
                    ack_d    = 1'b1;
                end
                if (en) begin
                    state_d = SHOW;
                    phase_d = SHOW_LD;
                end
            end
            SHOW: begin
                if (tick) begin
                    if (phase == '0) begin
                        if (BLANK_TICKS > 0) begin
                            state_d = BLANK;
                            phase_d = BLANK_LD;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        phase_d = phase - PW'(1);
                    end
                end
            end
            BLANK: begin
                if (tick) begin
                    if (phase == '0) advance = 1'b1;
                    else             phase_d = phase - PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            state_d = SHOW;
            phase_d = SHOW_LD;
            if (dig_idx == 3'd5) begin
                idx_d   = 3'd0;
                frame_d = 1'b1;
                if (upd_req) begin
                    shadow_d = bcd_in;
                    ack_d    = 1'b1;
                end
            end else begin
                idx_d = dig_idx + 3'd1;
            end
        end

        if (!en && state != IDLE) begin
            state_d  = IDLE;
            phase_d  = '0;
            idx_d    = 3'd0;
            shadow_d = shadow;
            ack_d    = 1'b0;
            frame_d  = 1'b0;
        end
    end

    // Display outputs derived from next state so they register with it; the
    // next shadow is used so reloaded data appears on digit 0 immediately.
    always_comb begin
        sel_d = 6'h3F;
        seg_d = 7'h00;
        digit = shadow_d[{idx_d, 2'b00} +: 4];
        if (state_d == SHOW) begin
            sel_d[idx_d] = 1'b0;
            if (LZB != 0 && idx_d != 3'd0 && lead_zero(shadow_d, idx_d)) seg_d = 7'h00;
            else                                                         seg_d = decode(digit);
        end
    end

    // State, shadow and registered outputs.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            phase      <= '0;
            dig_idx    <= 3'd0;
            shadow     <= 24'h0;
            upd_ack    <= 1'b0;
            frame_done <= 1'b0;
            dig_sel    <= 6'h3F;
            seg        <= 7'h00;
        end else begin
            state      <= state_d;
            phase      <= phase_d;
            dig_idx    <= idx_d;
            shadow     <= shadow_d;
            upd_ack    <= ack_d;
            frame_done <= frame_d;
            dig_sel    <= sel_d;
            seg        <= seg_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: one instance with a blank phase and one
// without, both at DIV=4, SHOW_TICKS=2, LZB=1.

module tb_seg_scan_ctrl;

    logic        mclk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        upd_req = 1'b0;
    logic [23:0] bcd_in = 24'h0;
    logic        upd_ack, frame_done;
    logic [5:0]  dig_sel;
    logic [6:0]  seg;
    logic [2:0]  dig_idx;

    logic        en2 = 1'b0;
    logic        req2 = 1'b0;
    logic [23:0] bcd2 = 24'h0;
    logic        ack2, fd2;
    logic [5:0]  sel2;
    logic [6:0]  seg2;
    logic [2:0]  idx2;

    int n_chk = 0;
    int n_fail = 0;

    seg_scan_ctrl #(.DIV(4), .SHOW_TICKS(2), .BLANK_TICKS(1), .LZB(1)) dut (
        .mclk(mclk), .rst(rst), .en(en), .upd_req(upd_req), .bcd_in(bcd_in),
        .upd_ack(upd_ack), .dig_sel(dig_sel), .seg(seg), .dig_idx(dig_idx),
        .frame_done(frame_done)
    );

    seg_scan_ctrl #(.DIV(4), .SHOW_TICKS(2), .BLANK_TICKS(0), .LZB(1)) dut_nb (
        .mclk(mclk), .rst(rst), .en(en2), .upd_req(req2), .bcd_in(bcd2),
        .upd_ack(ack2), .dig_sel(sel2), .seg(seg2), .dig_idx(idx2),
        .frame_done(fd2)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge mclk);
    endtask

    // At most one digit enable may be low at any time, on either instance.
    always @(negedge mclk) begin
        if (rst) begin
            check("onehot_sel", 32'($countones(~dig_sel) <= 1), 1);
            check("onehot_sel_nb", 32'($countones(~sel2) <= 1), 1);
        end
    end

    // Request a shadow load from the current point and check the frame that follows.
    task automatic load_frame(input string tag, input logic [23:0] bcd,
                              input logic [41:0] exp_seg, output int lat);
        logic [5:0] es;
        upd_req = 1'b1;
        bcd_in  = bcd;
        lat = 0;
        do begin
            step(1);
            lat++;
        end while (!upd_ack && lat < 200);
        check({tag, "_fd_with_ack"}, frame_done, 1);
        check({tag, "_idx0"}, dig_idx, 0);
        check({tag, "_sel0"}, dig_sel, 6'h3E);
        check({tag, "_seg0"}, seg, exp_seg[6:0]);
        upd_req = 1'b0;
        step(1);
        check({tag, "_ack_pulse"}, upd_ack, 0);
        step(11);
        for (int k = 1; k < 6; k++) begin
            if (k > 1) step(12);
            es = ~(6'b000001 << k);
            check({tag, "_idx"}, dig_idx, k);
            check({tag, "_sel"}, dig_sel, es);
            check({tag, "_seg"}, seg, exp_seg[7*k +: 7]);
        end
    endtask

    initial begin
        int n;
        int lat;

        // reset state
        step(2);
        check("rst_sel", dig_sel, 6'h3F);
        check("rst_seg", seg, 0);
        check("rst_idx", dig_idx, 0);
        check("rst_ack", upd_ack, 0);
        check("rst_fd", frame_done, 0);

        // 1: blank shadow, only digit 0 lit, 12-cycle digit, 72-cycle frame
        rst = 1'b1;
        en  = 1'b1;
        step(1);
        check("t1_sel0", dig_sel, 6'h3E);
        check("t1_seg0", seg, 7'h7E);
        check("t1_idx0", dig_idx, 0);
        step(7);
        check("t1_sel0_end", dig_sel, 6'h3E);
        step(1);
        check("t1_blank_sel", dig_sel, 6'h3F);
        check("t1_blank_seg", seg, 0);
        step(3);
        check("t1_blank_end", dig_sel, 6'h3F);
        step(1);
        check("t1_sel1", dig_sel, 6'h3D);
        check("t1_idx1", dig_idx, 1);
        check("t1_seg1_lzb", seg, 0);
        n = 0;
        do begin step(1); n++; end while (!frame_done && n < 200);
        check("t1_fd_first", n, 60);
        check("t1_fd_idx", dig_idx, 0);
        n = 0;
        do begin step(1); n++; end while (!frame_done && n < 200);
        check("t1_fd_period", n, 72);

        // 2: mid-frame request, ack lands on the next wrap
        step(20);
        load_frame("t2", 24'h012345,
                   {7'h00, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B}, lat);
        check("t2_ack_lat", lat, 52);

        // 3: non-decimal digit and interior zeros
        load_frame("t3", 24'h00A900,
                   {7'h00, 7'h00, 7'h00, 7'h7B, 7'h7E, 7'h7E}, lat);
        check("t3_ack_lat", lat, 12);

        // 4: disable during SHOW of digit 3, idle reload, restart at digit 0
        step(50);
        check("t4_idx3", dig_idx, 3);
        check("t4_sel3", dig_sel, 6'h37);
        check("t4_seg3_hex", seg, 0);
        en = 1'b0;
        step(1);
        check("t4_off_sel", dig_sel, 6'h3F);
        check("t4_off_idx", dig_idx, 0);
        check("t4_off_seg", seg, 0);
        upd_req = 1'b1;
        bcd_in  = 24'h000071;
        step(1);
        check("t4_idle_ack", upd_ack, 1);
        upd_req = 1'b0;
        step(1);
        check("t4_idle_ack_pulse", upd_ack, 0);
        en = 1'b1;
        step(1);
        check("t4_restart_sel", dig_sel, 6'h3E);
        check("t4_restart_idx", dig_idx, 0);
        check("t4_restart_seg", seg, 7'h30);
        step(12);
        check("t4_d1_sel", dig_sel, 6'h3D);
        check("t4_d1_seg", seg, 7'h70);

        // 5: asynchronous reset during BLANK after digit 1
        step(9);
        check("t5_pre_sel", dig_sel, 6'h3F);
        check("t5_pre_idx", dig_idx, 1);
        #2 rst = 1'b0;
        #1;
        check("t5_async_idx", dig_idx, 0);
        check("t5_async_sel", dig_sel, 6'h3F);
        check("t5_async_seg", seg, 0);
        check("t5_async_fd", frame_done, 0);
        @(negedge mclk);
        rst = 1'b1;
        step(1);
        check("t5_post_sel", dig_sel, 6'h3E);
        check("t5_post_seg_shadow0", seg, 7'h7E);

        // 6: no blank phase, 8-cycle digit, 48-cycle frame
        en2 = 1'b1;
        step(1);
        check("t6_sel0", sel2, 6'h3E);
        check("t6_seg0", seg2, 7'h7E);
        for (int i = 0; i < 7; i++) begin
            step(1);
            check("t6_sel0_hold", sel2, 6'h3E);
        end
        step(1);
        check("t6_sel1_noblank", sel2, 6'h3D);
        check("t6_idx1", idx2, 1);
        n = 0;
        do begin step(1); n++; end while (!fd2 && n < 200);
        check("t6_fd_first", n, 40);
        n = 0;
        do begin step(1); n++; end while (!fd2 && n < 200);
        check("t6_fd_period", n, 48);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
